// File: rtl/lsu_data_mem_responder.sv
// Data-memory responder for the LSU port: word-addressed RAM with sized,
// lane-aligned stores, sized and extended loads, and a fixed-latency
// in-order response pipeline.
module lsu_data_mem_responder #(
    parameter int DEPTH      = 1024,
    parameter int LATENCY    = 2,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_i,
    output logic                  gnt_o,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic                  we_i,
    input  logic [1:0]            type_i,
    input  logic [1:0]            extend_i,
    input  logic [31:0]           wdata_i,
    input  logic                  stall_i,
    output logic                  rvalid_o,
    output logic [31:0]           rdata_o,
    output logic                  err_o
);

    localparam int         IDX_W     = $clog2(DEPTH);
    localparam logic [1:0] TYPE_WORD = 2'b00;
    localparam logic [1:0] TYPE_HALF = 2'b01;
    localparam logic [1:0] EXT_SIGN  = 2'b01;

    // HALF must be 2-byte aligned, WORD 4-byte aligned; bytes are always legal.
    function automatic logic is_misaligned(input logic [1:0] typ, input logic [1:0] off);
        return ((typ == TYPE_WORD) && (off != 2'b00)) ||
               ((typ == TYPE_HALF) && off[0]);
    endfunction

    // Byte-lane write strobes for a store of the given size at the given offset.
    function automatic logic [3:0] store_strobe(input logic [1:0] typ, input logic [1:0] off);
        case (typ)
            TYPE_WORD: return 4'b1111;
            TYPE_HALF: return off[1] ? 4'b1100 : 4'b0011;
            default:   return 4'b0001 << off;
        endcase
    endfunction

    // Replicate the right-justified store data across lanes; the strobes
    // pick out the copy that lands on the addressed lane(s).
    function automatic logic [31:0] store_lanes(input logic [1:0] typ, input logic [31:0] wdata);
        case (typ)
            TYPE_WORD: return wdata;
            TYPE_HALF: return {2{wdata[15:0]}};
            default:   return {4{wdata[7:0]}};
        endcase
    endfunction

    // Shift the addressed lane(s) down to bit 0 and fill the upper bits
    // with the sign bit or zeros. WORD ignores the extension mode.
    function automatic logic [31:0] load_extract(input logic [31:0] word,
                                                 input logic [1:0]  typ,
                                                 input logic [1:0]  off,
                                                 input logic        sext);
        logic signed [7:0]  b;
        logic signed [15:0] h;
        b = word[{off, 3'b000} +: 8];
        h = word[{off[1], 4'b0000} +: 16];
        case (typ)
            TYPE_WORD: return word;
            TYPE_HALF: return sext ? 32'(h) : {16'h0000, h};
            default:   return sext ? 32'(b) : {24'h000000, b};
        endcase
    endfunction

    logic             accept;
    logic             out_of_range;
    logic             req_err;
    logic             sext;
    logic [1:0]       off;
    logic [IDX_W-1:0] idx;
    logic [3:0]       wstrb;
    logic [31:0]      wlanes;

    logic [31:0] mem [DEPTH];

    logic        vld_p0;
    logic        err_p0;
    logic        load_p0;
    logic        sext_p0;
    logic [1:0]  typ_p0;
    logic [1:0]  off_p0;
    logic [31:0] word_p0;

    logic        vld_pn  [1:LATENCY];
    logic        err_pn  [1:LATENCY];
    logic [31:0] data_pn [1:LATENCY];

    // Grant is purely combinational; backpressure and reset both block it.
    assign gnt_o  = req_i & ~stall_i & ~rst_i;
    assign accept = req_i & gnt_o;

    assign off          = addr_i[1:0];
    assign idx          = addr_i[IDX_W+1:2];
    assign out_of_range = |(addr_i >> (IDX_W + 2));
    assign req_err      = out_of_range | is_misaligned(type_i, off);
    assign sext         = (extend_i == EXT_SIGN);
    assign wstrb        = store_strobe(type_i, off);
    assign wlanes       = store_lanes(type_i, wdata_i);

    // Stores commit at the accept edge; erroring stores never touch the RAM.
    always_ff @(posedge clk_i) begin
        if (accept && we_i && !req_err) begin
            for (int b = 0; b < 4; b++) begin
                if (wstrb[b]) begin
                    mem[idx][8*b +: 8] <= wlanes[8*b +: 8];
                end
            end
        end
    end

    // ---- stage p0: RAM read and request attributes captured at accept ----
    always_ff @(posedge clk_i) begin
        if (accept) begin
            word_p0 <= mem[idx];
            err_p0  <= req_err;
            load_p0 <= ~we_i;
            sext_p0 <= sext;
            typ_p0  <= type_i;
            off_p0  <= off;
        end
    end

    // Stage p0 valid: one bit per accepted request, dropped on reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vld_p0 <= 1'b0;
        end else begin
            vld_p0 <= accept;
        end
    end

    // ---- stages p1..pN: formatted response shifted toward the output ----
    always_ff @(posedge clk_i) begin
        err_pn[1]  <= err_p0;
        data_pn[1] <= (load_p0 && !err_p0) ? load_extract(word_p0, typ_p0, off_p0, sext_p0)
                                           : 32'h0000_0000;
        for (int s = 2; s <= LATENCY; s++) begin
            err_pn[s]  <= err_pn[s-1];
            data_pn[s] <= data_pn[s-1];
        end
    end

    // Response valid line; reset clears every in-flight response.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int s = 1; s <= LATENCY; s++) begin
                vld_pn[s] <= 1'b0;
            end
        end else begin
            vld_pn[1] <= vld_p0;
            for (int s = 2; s <= LATENCY; s++) begin
                vld_pn[s] <= vld_pn[s-1];
            end
        end
    end

    // Data and error registers are not reset, so qualify them with valid.
    assign rvalid_o = vld_pn[LATENCY];
    assign err_o    = vld_pn[LATENCY] & err_pn[LATENCY];
    assign rdata_o  = vld_pn[LATENCY] ? data_pn[LATENCY] : 32'h0000_0000;

endmodule

// File: tb/tb_lsu_data_mem_responder.sv
// Bench for lsu_data_mem_responder: three builds (LATENCY 1, 2, 4) share one
// stimulus stream and are scored against a byte-array memory model.
module tb_lsu_data_mem_responder;

    localparam int DEPTH = 64;
    localparam int NCYC  = 8192;

    localparam logic [1:0] W = 2'b00, H = 2'b01, B = 2'b10, B2 = 2'b11;
    localparam logic [1:0] ZX = 2'b00, SX = 2'b01;

    logic        clk = 1'b0;
    logic        rst, req, we, stall;
    logic [1:0]  typ, ext;
    logic [31:0] addr, wdata;

    logic        gnt1, gnt2, gnt4;
    logic        rv1, rv2, rv4;
    logic        er1, er2, er4;
    logic [31:0] rd1, rd2, rd4;

    always #5 clk = ~clk;

    lsu_data_mem_responder #(.DEPTH(DEPTH), .LATENCY(2), .ADDR_WIDTH(32)) u_dut (
        .clk_i(clk), .rst_i(rst), .req_i(req), .gnt_o(gnt2), .addr_i(addr),
        .we_i(we), .type_i(typ), .extend_i(ext), .wdata_i(wdata), .stall_i(stall),
        .rvalid_o(rv2), .rdata_o(rd2), .err_o(er2));

    lsu_data_mem_responder #(.DEPTH(DEPTH), .LATENCY(1), .ADDR_WIDTH(32)) u_dut_l1 (
        .clk_i(clk), .rst_i(rst), .req_i(req), .gnt_o(gnt1), .addr_i(addr),
        .we_i(we), .type_i(typ), .extend_i(ext), .wdata_i(wdata), .stall_i(stall),
        .rvalid_o(rv1), .rdata_o(rd1), .err_o(er1));

    lsu_data_mem_responder #(.DEPTH(DEPTH), .LATENCY(4), .ADDR_WIDTH(32)) u_dut_l4 (
        .clk_i(clk), .rst_i(rst), .req_i(req), .gnt_o(gnt4), .addr_i(addr),
        .we_i(we), .type_i(typ), .extend_i(ext), .wdata_i(wdata), .stall_i(stall),
        .rvalid_o(rv4), .rdata_o(rd4), .err_o(er4));

    // Reference model state: byte memory plus per-edge accept/reset history.
    logic [7:0]  ref_mem [DEPTH*4];
    bit          acc     [NCYC];
    bit          rst_at  [NCYC];
    logic        err_exp [NCYC];
    logic [31:0] dat_exp [NCYC];

    int cyc      = 0;
    int n_checks = 0;
    int n_pass   = 0;
    bit armed    = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s @cycle %0d: got 0x%08h expected 0x%08h", tag, cyc, got, exp);
    endtask

    // A response is due lat edges after its accept unless a reset edge fell in between.
    function automatic bit resp_due(input int lat, input int k);
        if (k - lat < 0 || k >= NCYC) return 1'b0;
        if (!acc[k-lat]) return 1'b0;
        for (int j = k - lat + 1; j <= k; j++) if (rst_at[j]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic check_port(input string name, input int lat, input logic rv,
                              input logic er, input logic [31:0] rd);
        bit          v;
        logic        e;
        logic [31:0] d;
        v = resp_due(lat, cyc);
        e = 1'b0;
        d = 32'h0;
        if (v) begin
            e = err_exp[cyc-lat];
            d = dat_exp[cyc-lat];
        end
        check_eq({name, " rvalid"}, 32'(rv), 32'(v));
        check_eq({name, " err"},    32'(er), 32'(e));
        check_eq({name, " rdata"},  rd, d);
    endtask

    // Behavioural access: size in bytes, alignment by modulo, little-endian bytes.
    task automatic model(input logic w, input logic [1:0] t, input logic [1:0] e,
                         input logic [31:0] a, input logic [31:0] wd,
                         output logic er, output logic [31:0] d);
        int          sz;
        logic [31:0] v;
        sz = (t == 2'b00) ? 4 : (t == 2'b01) ? 2 : 1;
        er = ((a % sz) != 0) || (a >= DEPTH*4);
        d  = 32'h0;
        if (!er) begin
            if (w) begin
                for (int i = 0; i < sz; i++) ref_mem[a+i] = wd[8*i +: 8];
            end else begin
                v = 32'h0;
                for (int i = 0; i < sz; i++) v[8*i +: 8] = ref_mem[a+i];
                if (e == 2'b01 && sz < 4 && v[8*sz-1])
                    for (int i = 8*sz; i < 32; i++) v[i] = 1'b1;
                d = v;
            end
        end
    endtask

    task automatic step(input logic r_rst, input logic r_req, input logic r_we,
                        input logic [1:0] r_typ, input logic [1:0] r_ext,
                        input logic [31:0] r_addr, input logic [31:0] r_wd,
                        input logic r_stall, output bit granted);
        logic        g;
        logic        me;
        logic [31:0] md;
        @(negedge clk);
        if (armed) begin
            check_port("lat1", 1, rv1, er1, rd1);
            check_port("lat2", 2, rv2, er2, rd2);
            check_port("lat4", 4, rv4, er4, rd4);
        end
        rst = r_rst; req = r_req; we = r_we; typ = r_typ; ext = r_ext;
        addr = r_addr; wdata = r_wd; stall = r_stall;
        #1;
        g = r_req & ~r_stall & ~r_rst;
        check_eq("gnt lat1", 32'(gnt1), 32'(g));
        check_eq("gnt lat2", 32'(gnt2), 32'(g));
        check_eq("gnt lat4", 32'(gnt4), 32'(g));
        if (cyc + 1 < NCYC) begin
            rst_at[cyc+1] = r_rst;
            acc[cyc+1]    = g;
            if (g) begin
                model(r_we, r_typ, r_ext, r_addr, r_wd, me, md);
                err_exp[cyc+1] = me;
                dat_exp[cyc+1] = md;
            end
        end
        granted = g;
        @(posedge clk);
        cyc++;
        if (r_rst) armed = 1'b1;
    endtask

    task automatic ld(input logic [1:0] t, input logic [1:0] e, input logic [31:0] a);
        bit g;
        step(1'b0, 1'b1, 1'b0, t, e, a, 32'h0, 1'b0, g);
    endtask

    task automatic st(input logic [1:0] t, input logic [31:0] a, input logic [31:0] wd);
        bit g;
        step(1'b0, 1'b1, 1'b1, t, ZX, a, wd, 1'b0, g);
    endtask

    task automatic idle(input int n);
        bit g;
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, W, ZX, 32'h0, 32'h0, 1'b0, g);
    endtask

    initial begin
        bit          g;
        bit          hold;
        logic        r_req, r_we, r_stall, r_rst;
        logic [1:0]  r_typ, r_ext;
        logic [31:0] r_addr, r_wd;

        // Reset with a request pending: it must not be granted.
        step(1'b1, 1'b1, 1'b0, W, ZX, 32'h10, 32'h0, 1'b0, g);
        step(1'b1, 1'b1, 1'b0, W, ZX, 32'h10, 32'h0, 1'b0, g);
        idle(2);

        // Give every word a known value.
        for (int i = 0; i < DEPTH; i++) st(W, 32'(i*4), $urandom);
        idle(4);

        // Aligned word round trip.
        st(W, 32'h10, 32'hDEADBEEF);
        ld(W, ZX, 32'h10);
        idle(4);

        // Sub-word stores and extended loads.
        st(W, 32'h20, 32'h0);
        st(B, 32'h21, 32'h80);
        st(H, 32'h22, 32'hF00D);
        ld(W, ZX, 32'h20);
        ld(B, SX, 32'h21);
        ld(B, ZX, 32'h21);
        ld(H, SX, 32'h22);
        ld(B2, SX, 32'h23);
        ld(H, ZX, 32'h22);
        idle(4);

        // Error cases.
        ld(H, ZX, 32'h13);
        st(W, 32'h0E, 32'h12345678);
        ld(W, ZX, 32'h0C);
        ld(W, ZX, 32'(DEPTH*4));
        st(B, 32'hFFFF_FF00, 32'h55);
        idle(4);

        // Back-to-back loads, second one stalled for a cycle and held.
        ld(W, ZX, 32'h10);
        step(1'b0, 1'b1, 1'b0, W, ZX, 32'h20, 32'h0, 1'b1, g);
        ld(W, ZX, 32'h20);
        ld(W, ZX, 32'h0C);
        ld(W, ZX, 32'h24);
        st(W, 32'h30, 32'hCAFEF00D);
        ld(W, ZX, 32'h30);
        idle(4);

        // Reset one edge after an accept drops the response.
        ld(W, ZX, 32'h10);
        step(1'b1, 1'b1, 1'b0, W, ZX, 32'h14, 32'h0, 1'b0, g);
        idle(5);

        // Randomized traffic with stalls, held requests and occasional resets.
        hold = 1'b0;
        r_req = 1'b0; r_we = 1'b0; r_typ = W; r_ext = ZX; r_addr = 32'h0; r_wd = 32'h0;
        for (int n = 0; n < 1500; n++) begin
            if (!hold) begin
                r_req = ($urandom_range(0, 9) < 7);
                r_we  = 1'($urandom_range(0, 1));
                r_typ = 2'($urandom_range(0, 3));
                r_ext = 2'($urandom_range(0, 3));
                case ($urandom_range(0, 19))
                    0:       r_addr = $urandom;
                    1:       r_addr = 32'(DEPTH*4 + $urandom_range(0, 63));
                    default: r_addr = 32'($urandom_range(0, DEPTH*4 - 1));
                endcase
                r_wd = $urandom;
            end
            r_stall = ($urandom_range(0, 6) == 0);
            r_rst   = ($urandom_range(0, 99) == 0);
            step(r_rst, r_req, r_we, r_typ, r_ext, r_addr, r_wd, r_stall, g);
            hold = r_req && !g;
        end
        idle(6);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/lsu_data_mem_responder.md
Name: lsu_data_mem_responder

Overview:
- Memory-side responder for the core's load/store unit (LSU) data interface.
- Accepts LSU requests with a req/gnt handshake and carries the `we_e`, `type_e` and `extend_e` encodings from riscv_pkg.
- Performs sized, lane-aligned stores, and sized, extended loads, against an internal word-addressed RAM.
- Returns a response after a fixed pipelined latency; used as the data memory in the core testbench and in small SoC builds.

Parameters:
- DEPTH, 1024, number of 32-bit words in the RAM (power of two).
- LATENCY, 2, cycles from request acceptance to rvalid (legal range 1..4).
- ADDR_WIDTH, 32, byte address width.

Ports:
- clk_i  input  1  system clock.
- rst_i  input  1  synchronous, active-high reset.
- req_i  input  1  LSU request valid.
- gnt_o  output  1  request accepted this cycle.
- addr_i  input  ADDR_WIDTH  byte address.
- we_i  input  1  `we_e`: 0 = LOAD, 1 = STORE.
- type_i  input  2  `type_e`: 00 = WORD, 01 = HALF, 10/11 = BYTE (BYTE1 and BYTE2 are identical here).
- extend_i  input  2  `extend_e`: 00 = ZERO_EXT, 01 = SIGN_EXT; 1x is treated as ZERO_EXT.
- wdata_i  input  32  store data, right-justified (bits [7:0] for a byte, [15:0] for a half).
- stall_i  input  1  test backpressure; forces gnt_o low.
- rvalid_o  output  1  response valid.
- rdata_o  output  32  load result after alignment and extension; 0 for stores and errors.
- err_o  output  1  error flag, qualified by rvalid_o.

Behaviour:
- One clock (clk_i). Reset is synchronous and active-high (rst_i).
- Reset values:
  - rvalid_o=0, err_o=0, rdata_o=0.
  - All pipeline valid bits are cleared.
  - RAM contents are not reset.
- Handshake:
  - gnt_o = req_i & ~stall_i & ~rst_i, combinational.
  - A request is accepted on a clock edge where req_i & gnt_o.
  - The requester holds all request fields stable until the request is granted.
- Error checks, evaluated on the accepted request:
  - Misaligned: HALF with addr[0]=1, or WORD with addr[1:0]≠0.
  - Out of range: addr ≥ DEPTH*4.
  - An erroring access never writes the RAM, and its response has err_o=1, rdata_o=0.
- Store, committed at the accept edge:
  - WORD writes all four bytes.
  - HALF writes byte lanes {addr[1]*2, addr[1]*2+1}.
  - BYTE writes lane addr[1:0].
  - Write data is wdata_i shifted to the selected lane(s); unselected lanes keep their contents.
- Load:
  - The RAM word is read at the accept edge.
  - The selected lane(s) are shifted down to bit 0.
  - Upper bits are filled with the sign bit (SIGN_EXT) or zeros.
  - WORD ignores extend_i.
- Ordering: a write committed at edge T is visible to a read accepted at edge T+1 or later.
- Response pipeline:
  - A LATENCY-deep shift register of {valid, err, data}.
  - A request accepted at edge T produces rvalid_o=1 for exactly one cycle, starting at edge T+LATENCY.
  - Stores respond too, with rdata_o=0.
- Throughput: one request per cycle. At most LATENCY requests are outstanding; responses return in order and are never back-pressured.
- Idle cycles: no request accepted → rvalid_o=0 in the corresponding response cycle; rdata_o and err_o are 0 whenever rvalid_o=0.
- Reset mid-operation: all in-flight responses are dropped. A store already committed before the reset edge remains in the RAM; a request presented during reset is not granted.
- stall_i high: no accept. Responses already in the pipeline still drain on schedule.

Test Plan:
- Aligned word: store 0xDEADBEEF to 0x10, then load WORD from 0x10 → rvalid_o exactly 2 cycles after each grant; load returns rdata 0xDEADBEEF, err_o=0.
- Byte and half stores and extended loads:
  - Store BYTE 0x80 to 0x21, then HALF 0xF00D to 0x22, on a word pre-set to 0x00000000.
  - Load WORD from 0x20 → 0xF00D8000.
  - Load BYTE SIGN_EXT from 0x21 → 0xFFFFFF80.
  - Load BYTE ZERO_EXT from 0x21 → 0x00000080.
  - Load HALF SIGN_EXT from 0x22 → 0xFFFFF00D.
- Errors:
  - Load HALF from 0x13 → err_o=1, rdata_o=0.
  - Store WORD 0x12345678 to 0x0E (misaligned) → err_o=1; a later load WORD from 0x0C shows the word unchanged.
  - Load WORD from DEPTH*4 → err_o=1.
- Back-to-back with stall:
  - Issue 4 consecutive loads with stall_i high in cycle 2.
  - Expect gnt_o low that cycle and responses in request order.
  - Store followed by a load to the same address on the next cycle returns the new data.
- Reset mid-flight:
  - Accept a load at edge T, assert rst_i at edge T+1.
  - Expect no rvalid_o at T+2, and gnt_o=0 while rst_i=1.
- LATENCY=1 and LATENCY=4 builds: a single load → rvalid_o at T+1 and T+4 respectively, one cycle wide.
